// File: rtl/cpu_operand_fetch_if.sv
// cpu_operand_fetch_if: command, status and memory-bus signals of the operand-fetch sequencer.
interface cpu_operand_fetch_if #(parameter int ADDR_W = 16);
  logic              start;
  logic [2:0]        mode;
  logic [7:0]        index;
  logic              write;
  logic [7:0]        wdata;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic [7:0]        data_bus_in;
  logic [ADDR_W-1:0] adr_bus;
  logic              RW;
  logic              busy;
  logic              done;
  logic [7:0]        rdata;
  logic [ADDR_W-1:0] eff_adr;
  logic [ADDR_W-1:0] pc_val;
  logic              err;
  modport master (
    output start, mode, index, write, wdata, pc_load, pc_load_val, data_bus_in,
    input  adr_bus, RW, busy, done, rdata, eff_adr, pc_val, err
  );
  modport slave (
    input  start, mode, index, write, wdata, pc_load, pc_load_val, data_bus_in,
    output adr_bus, RW, busy, done, rdata, eff_adr, pc_val, err
  );
endinterface

// File: rtl/cpu_operand_fetch.sv
// cpu_operand_fetch: PC owner and operand-fetch / effective-address sequencer, state on falling clock edge.
module cpu_operand_fetch #(
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h8000,
  parameter int unsigned ZP_PAGE  = 0
) (
  input  logic                clk,
  input  logic                n_reset,
  cpu_operand_fetch_if.slave  bus,
  output logic [7:0]          data_bus_out
);
  localparam int HW = ADDR_W - 8;
  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
  localparam logic [HW-1:0] ZPG = HW'(ZP_PAGE);
  localparam logic [2:0] M_IMP = 3'd0, M_IMM = 3'd1, M_ZP = 3'd2, M_ZPX = 3'd3, M_ABSX = 3'd5;
  typedef enum logic [2:0] {IDLE, OP_LO, OP_HI, FIX, ACCESS} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, adr, adr_n, eff, eff_n;
  logic [7:0] rdata, rdata_n, index_q, index_n, wdata_q, wdata_n, lo, lo_n;
  logic [HW-1:0] hi, hi_n;
  logic [2:0] mode_q, mode_n;
  logic rw, rw_n, done, done_n, err, err_n, write_q, write_n, carry, carry_n;
  logic [8:0] sum;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    adr_n   = adr;
    eff_n   = eff;
    rdata_n = rdata;
    done_n  = 1'b0;
    err_n   = err;
    mode_n  = mode_q;
    index_n = index_q;
    write_n = write_q;
    wdata_n = wdata_q;
    lo_n    = lo;
    hi_n    = hi;
    carry_n = carry;
    // index is added only for the indexed modes; ZPX drops the carry so it stays in the page
    sum = {1'b0, bus.data_bus_in} + {1'b0, (mode_q == M_ZPX || mode_q == M_ABSX) ? index_q : 8'h00};
    case (state)
      IDLE: begin
        if (bus.pc_load) pc_n = bus.pc_load_val;
        else if (bus.start) begin
          if (bus.mode == M_IMP || bus.mode > M_ABSX) begin
            done_n = 1'b1;
            err_n  = err | (bus.mode > M_ABSX);
          end else begin
            mode_n  = bus.mode;
            index_n = bus.index;
            write_n = bus.write;
            wdata_n = bus.wdata;
            state_n = OP_LO;
          end
        end
      end
      OP_LO: begin
        pc_n = pc + 1'b1;
        if (mode_q == M_IMM) begin
          rdata_n = bus.data_bus_in;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (mode_q == M_ZP || mode_q == M_ZPX) begin
          lo_n    = sum[7:0];
          adr_n   = {ZPG, sum[7:0]};
          state_n = ACCESS;
        end else begin
          lo_n    = sum[7:0];
          carry_n = sum[8];
          adr_n   = pc_n;
          state_n = OP_HI;
        end
      end
      OP_HI: begin
        pc_n    = pc + 1'b1;
        hi_n    = bus.data_bus_in[HW-1:0];
        adr_n   = {hi_n, lo};
        // indexed stores always take the fix-up slot so the write never hits an unfixed address
        state_n = (mode_q == M_ABSX && (carry || write_q)) ? FIX : ACCESS;
      end
      FIX: begin
        adr_n   = {hi + HW'(carry), lo};
        state_n = ACCESS;
      end
      ACCESS: begin
        if (!write_q) rdata_n = bus.data_bus_in;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) adr_n = pc_n;
    if (state_n == ACCESS) eff_n = adr_n;
    rw_n = !(state_n == ACCESS && write_q);
  end
  always_ff @(negedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      pc      <= RST_PC;
      adr     <= RST_PC;
      eff     <= '0;
      rdata   <= 8'h00;
      rw      <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      mode_q  <= M_IMP;
      index_q <= 8'h00;
      write_q <= 1'b0;
      wdata_q <= 8'h00;
      lo      <= 8'h00;
      hi      <= '0;
      carry   <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      adr     <= adr_n;
      eff     <= eff_n;
      rdata   <= rdata_n;
      rw      <= rw_n;
      done    <= done_n;
      err     <= err_n;
      mode_q  <= mode_n;
      index_q <= index_n;
      write_q <= write_n;
      wdata_q <= wdata_n;
      lo      <= lo_n;
      hi      <= hi_n;
      carry   <= carry_n;
    end
  end
  assign bus.adr_bus   = adr;
  assign bus.RW        = rw;
  assign bus.busy      = state != IDLE;
  assign bus.done      = done;
  assign bus.rdata     = rdata;
  assign bus.eff_adr   = eff;
  assign bus.pc_val    = pc;
  assign bus.err       = err;
  assign data_bus_out  = rw ? 8'hzz : wdata_q;
endmodule
